// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared types and sizing helpers for the matrix-multiply front end
package mmul_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  localparam int MMUL_N       = 4;
  localparam int CNT_W        = $clog2(MMUL_N) + 1;
  localparam int FLUSH_CYCLES = MMUL_N;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Zero columns needed for an n-deep skew stage to drain completely.
  function automatic int flush_cycles(input int n);
    return n;
  endfunction

endpackage

// File: rtl/activation_column_bank.sv
// rtl/activation_column_bank.sv - column register file, one sync write port, one async read port
module activation_column_bank #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately unreset; contents are only read after a full load.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/activation_streamer.sv
// rtl/activation_streamer.sv - loads an NxN activation tile by columns and replays it, then flushes, into input_buffer
module activation_streamer
  import mmul_pkg::*;
#(
  parameter int N          = MMUL_N,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [N*DATA_WIDTH-1:0] stream_data,
  output logic                    stream_enable
);

  localparam int W  = N * DATA_WIDTH;
  localparam int CW = cnt_width(N);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COL   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(flush_cycles(N) - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0] str_cnt_q, str_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          enable_q, enable_d;
  logic [W-1:0]  data_q, data_d;

  logic          bank_we;
  logic [AW-1:0] bank_waddr;
  logic [AW-1:0] bank_raddr;
  logic [W-1:0]  bank_rdata;

  assign bank_we    = in_valid && in_ready_q;
  assign bank_waddr = AW'(col_cnt_q);
  // Look one column ahead while streaming; column 0 is prefetched in FULL.
  assign bank_raddr = (state_q == STREAM && str_cnt_q != LAST_COL) ? AW'(str_cnt_q + ONE) : '0;

  activation_column_bank #(
    .DEPTH (N),
    .WIDTH (W),
    .AW    (AW)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (bank_we),
    .waddr_i (bank_waddr),
    .wdata_i (in_data),
    .raddr_i (bank_raddr),
    .rdata_o (bank_rdata)
  );

  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    str_cnt_d  = str_cnt_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    enable_d   = enable_q;
    data_d     = data_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          if (col_cnt_q == LAST_COL) begin
            state_d    = FULL;
            col_cnt_d  = '0;
            in_ready_d = 1'b0;
          end else begin
            col_cnt_d = col_cnt_q + ONE;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_d   = STREAM;
          str_cnt_d = '0;
          busy_d    = 1'b1;
          enable_d  = 1'b1;
          data_d    = bank_rdata;
        end
      end
      STREAM: begin
        if (str_cnt_q == LAST_COL) begin
          state_d   = FLUSH;
          str_cnt_d = '0;
          data_d    = '0;
          done_d    = (LAST_FLUSH == '0);
        end else begin
          str_cnt_d = str_cnt_q + ONE;
          data_d    = bank_rdata;
        end
      end
      FLUSH: begin
        if (str_cnt_q == LAST_FLUSH) begin
          state_d    = LOAD;
          str_cnt_d  = '0;
          enable_d   = 1'b0;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end else begin
          str_cnt_d = str_cnt_q + ONE;
          done_d    = ((str_cnt_q + ONE) == LAST_FLUSH);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      col_cnt_q  <= '0;
      str_cnt_q  <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      enable_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      str_cnt_q  <= str_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      enable_q   <= enable_d;
      data_q     <= data_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign stream_enable = enable_q;
  assign stream_data   = data_q;

endmodule

// File: tb/tb_activation_streamer.sv
// tb/tb_activation_streamer.sv - randomized self-checking bench for activation_streamer
module tb_activation_streamer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;

  typedef logic [N-1:0][W-1:0] tile_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] stream_data;
  logic         stream_enable;

  int n_cmp = 0;
  int n_bad = 0;

  activation_streamer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .stream_data   (stream_data),
    .stream_enable (stream_enable)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_idle(input string tag);
    expect_eq({tag, "_ready"}, in_ready, 1);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_done"}, done, 0);
    expect_eq({tag, "_en"}, stream_enable, 0);
    expect_eq({tag, "_data"}, stream_data, 0);
  endtask

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < N; i++) t[i] = $urandom;
    return t;
  endfunction

  // Feed N beats; gappy toggles in_valid, poke_start drops a start mid-load.
  // Afterwards sit in FULL for a few cycles offering junk beats.
  task automatic load_tile(input tile_t tile, input bit gappy, input bit poke_start);
    int k = 0;
    int cyc = 0;
    while (k < N) begin
      @(negedge clk);
      expect_eq("ld_ready", in_ready, 1);
      expect_eq("ld_en", stream_enable, 0);
      expect_eq("ld_busy", busy, 0);
      in_valid = gappy ? ((cyc % 2) == 0) : 1'b1;
      in_data  = in_valid ? tile[k] : $urandom;
      start    = poke_start && (cyc == 3);
      if (in_valid) k++;
      cyc++;
    end
    repeat (1 + $urandom_range(0, 3)) begin
      @(negedge clk);
      expect_eq("full_ready", in_ready, 0);
      expect_eq("full_en", stream_enable, 0);
      expect_eq("full_busy", busy, 0);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
    end
  endtask

  // Expected stream: the stored columns in order, then N zero columns.
  task automatic stream_tile(input tile_t tile, input int reset_at);
    logic [W-1:0] exp_q [$];
    for (int i = 0; i < N; i++) exp_q.push_back(tile[i]);
    for (int i = 0; i < N; i++) exp_q.push_back('0);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      if (i == reset_at) begin
        #2 reset = 1'b0;
        #1;
        expect_idle("async_rst");
        @(negedge clk);
        expect_idle("held_rst");
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        return;
      end
      expect_eq("st_en", stream_enable, 1);
      expect_eq("st_busy", busy, 1);
      expect_eq("st_ready", in_ready, 0);
      expect_eq("st_data", stream_data, exp_q[i]);
      expect_eq("st_done", done, (i == 2 * N - 1));
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    expect_idle("post");
  endtask

  initial begin
    tile_t t;
    repeat (2) @(negedge clk);
    expect_idle("in_rst");
    reset = 1'b1;
    @(negedge clk);
    expect_idle("rst_rel");

    t[0] = 32'h04030201;
    t[1] = 32'h08070605;
    t[2] = 32'h0C0B0A09;
    t[3] = 32'h100F0E0D;
    load_tile(t, 1'b0, 1'b0);
    stream_tile(t, -1);

    t = rand_tile();
    load_tile(t, 1'b1, 1'b1);
    stream_tile(t, -1);

    t = rand_tile();
    load_tile(t, 1'b0, 1'b0);
    stream_tile(t, 1);

    t = rand_tile();
    load_tile(t, 1'b0, 1'b1);
    stream_tile(t, -1);

    for (int r = 0; r < 6; r++) begin
      t = rand_tile();
      load_tile(t, $urandom_range(0, 1), $urandom_range(0, 1));
      stream_tile(t, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
